cache_control: RTL
==================

Name: cache_control

Overview:
- Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache. The line is 128 bits, the tag 9 bits, the index 3 bits and the offset 4 bits.
- Sits between the CPU memory port, the cache datapath and physical memory.
- Decides hit or miss, selects the victim by LRU, sequences writeback and line fill, and drives every array write enable and mux select in the datapath.
- Keeps saturating hit and miss counters for performance debug.

Parameters:
- CNT_WIDTH, 16, width of the hit_count and miss_count registers.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_resp  out  1  one-cycle CPU completion pulse
- hit0, hit1  in  1 each  tag-compare results of way 0 and way 1 (tag only, not qualified by valid)
- valid_out0, valid_out1  in  1 each  valid bits of the indexed set
- dirty_out0, dirty_out1  in  1 each  dirty bits of the indexed set
- lru_out  in  1  LRU way of the indexed set (the way to evict)
- data0_write, data1_write, tag0_write, tag1_write  out  1 each  array write enables
- dirty0_write, dirty1_write, valid0_write, valid1_write, lru_write  out  1 each  array write enables
- dirty_bit, valid_bit, lru_bit  out  1 each  write data for the dirty, valid and LRU arrays
- inmux_sel  out  lc3b_cache_inmux_sel  data-array source: CACHE_IN_PMEM or CACHE_IN_CPU
- hitmux_sel  out  lc3b_cache_hitmux_sel  selects the way driving the line output: 1 = way 0, 0 = way 1
- addrmux_sel  out  lc3b_cache_addrmux_sel  pmem_address source: ADDR_CPU = {cpu tag, index, 4'b0}; ADDR_WB = {victim tag, index, 4'b0}
- pmem_read, pmem_write  out  1 each  physical-memory requests
- pmem_resp  in  1  physical-memory completion
- hit_count, miss_count  out  CNT_WIDTH each  saturating performance counters

Behaviour:
- Way hit definition: wayN_hit = hitN & valid_outN. The request is a hit if either way hits. If both ways hit, way 0 wins.
- Request priority: if mem_read and mem_write are both high, the request is treated as a write.
- Output defaults: every output is 0 unless the current state or transition drives it. This includes all write enables, pmem_read, pmem_write and mem_resp. Default selects are inmux_sel = CACHE_IN_PMEM, addrmux_sel = ADDR_CPU, hitmux_sel = way of the current hit.
- Reset: state goes to S_IDLE, both counters clear to 0, every output is at its default in the cycle after rst.
  - Reset mid-operation abandons any pmem transaction; pmem_read and pmem_write drop the next cycle.
  - Reset does not clear the arrays.
- State S_IDLE (compare state), with no request: stay, all outputs at default.
- S_IDLE, read hit: combinational in the same cycle.
  - mem_resp = 1 and hitmux_sel = the hit way.
  - lru_write = 1 with lru_bit = the other way.
  - hit_count increments. Stay in S_IDLE.
  - Hit latency is 1 cycle.
- S_IDLE, write hit: as a read hit, plus:
  - dataN_write = 1 and inmux_sel = CACHE_IN_CPU for the hit way.
  - dirtyN_write = 1 with dirty_bit = 1.
- S_IDLE, miss: the victim is way lru_out.
  - miss_count increments once, on the cycle that leaves S_IDLE.
  - If the victim is valid and dirty, go to S_WRITEBACK; otherwise go to S_FILL.
- S_WRITEBACK:
  - Drive pmem_write = 1, addrmux_sel = ADDR_WB, hitmux_sel = victim.
  - Hold until pmem_resp; on pmem_resp go to S_FILL.
- S_FILL:
  - Drive pmem_read = 1, addrmux_sel = ADDR_CPU.
  - On pmem_resp, for the victim way: dataV_write = 1 (inmux_sel = CACHE_IN_PMEM), tagV_write = 1, validV_write = 1 with valid_bit = 1, dirtyV_write = 1 with dirty_bit = 0. Then go to S_IDLE.
  - No mem_resp is driven in S_FILL. The re-compare in S_IDLE hits and completes the request, but counts toward miss only (that hit does not increment hit_count).
- Counter bookkeeping: a registered flag suppresses hit_count for the first S_IDLE cycle after S_FILL.
- Counters saturate at all-ones and never wrap.
- The CPU must hold its address and request stable until mem_resp. mem_resp is never asserted outside S_IDLE.
- pmem_read and pmem_write are never asserted together.

Decomposition:
- lc3b_ctypes holds: lc3b_cache_inmux_sel, lc3b_cache_hitmux_sel, new lc3b_cache_addrmux_sel, and the state enum lc3b_cache_state_t (S_IDLE, S_WRITEBACK, S_FILL).
- Sub-module sat_counter (parameter width; inputs inc and rst) is instantiated twice, for hit_count and miss_count.

Test Plan:
1. rst = 1 for 2 cycles with mem_read = 1 → mem_resp = 0, pmem_read = pmem_write = 0, hit_count = miss_count = 0, state S_IDLE.
2. Read, hit1 = valid_out1 = 1, hit0 = 0 → same cycle: mem_resp = 1, hitmux_sel = 0, lru_write = 1, lru_bit = 0; hit_count goes 0 → 1.
3. Write, hit0 = valid_out0 = 1 → data0_write = dirty0_write = 1, dirty_bit = 1, inmux_sel = CACHE_IN_CPU, mem_resp = 1; no pmem activity.
4. Read miss, lru_out = 1, valid_out1 = dirty_out1 = 1 → S_WRITEBACK with pmem_write = 1, addrmux_sel = ADDR_WB, held for 5 cycles until pmem_resp. Then S_FILL with pmem_read = 1. On pmem_resp: data1/tag1/valid1/dirty1 writes, dirty_bit = 0. Next cycle: mem_resp = 1; miss_count = 1, hit_count unchanged.
5. Write miss, lru_out = 0, victim clean → straight to S_FILL with no pmem_write. After fill, the compare hit writes data0 with CACHE_IN_CPU and sets dirty0.
6. rst asserted in S_WRITEBACK before pmem_resp → next cycle pmem_write = 0, state S_IDLE. Then drive 2^16 + 3 read hits → hit_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller: datapath mux selects and FSM state encoding.
package lc3b_ctypes;

  typedef enum logic {
    CACHE_IN_PMEM = 1'b0,
    CACHE_IN_CPU  = 1'b1
  } lc3b_cache_inmux_sel;

  // Encoding follows the datapath mux: 1 routes way 0, 0 routes way 1.
  typedef enum logic {
    HITMUX_WAY1 = 1'b0,
    HITMUX_WAY0 = 1'b1
  } lc3b_cache_hitmux_sel;

  typedef enum logic {
    ADDR_CPU = 1'b0,
    ADDR_WB  = 1'b1
  } lc3b_cache_addrmux_sel;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } lc3b_cache_state_t;

  function automatic lc3b_cache_hitmux_sel way_to_hitmux(input logic way);
    return way ? HITMUX_WAY1 : HITMUX_WAY0;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {Width{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative write-back L1 cache: hit/miss decision,
// LRU victim selection, writeback/fill sequencing and all datapath write enables.
module cache_control
  import lc3b_ctypes::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic                  mem_resp,
  input  logic                  hit0,
  input  logic                  hit1,
  input  logic                  valid_out0,
  input  logic                  valid_out1,
  input  logic                  dirty_out0,
  input  logic                  dirty_out1,
  input  logic                  lru_out,
  output logic                  data0_write,
  output logic                  data1_write,
  output logic                  tag0_write,
  output logic                  tag1_write,
  output logic                  dirty0_write,
  output logic                  dirty1_write,
  output logic                  valid0_write,
  output logic                  valid1_write,
  output logic                  lru_write,
  output logic                  dirty_bit,
  output logic                  valid_bit,
  output logic                  lru_bit,
  output lc3b_cache_inmux_sel   inmux_sel,
  output lc3b_cache_hitmux_sel  hitmux_sel,
  output lc3b_cache_addrmux_sel addrmux_sel,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  lc3b_cache_state_t state_q, state_d;
  logic fill_done_q, fill_done_d;
  logic hit_inc, miss_inc;

  logic way0_hit, way1_hit, any_hit, hit_way, req;
  logic victim, victim_dirty;

  assign way0_hit     = hit0 & valid_out0;
  assign way1_hit     = hit1 & valid_out1;
  assign any_hit      = way0_hit | way1_hit;
  assign hit_way      = ~way0_hit;  // way 0 wins a double hit
  assign req          = mem_read | mem_write;
  assign victim       = lru_out;
  assign victim_dirty = victim ? (valid_out1 & dirty_out1) : (valid_out0 & dirty_out0);

  always_comb begin
    state_d      = state_q;
    fill_done_d  = 1'b0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    mem_resp     = 1'b0;
    data0_write  = 1'b0;
    data1_write  = 1'b0;
    tag0_write   = 1'b0;
    tag1_write   = 1'b0;
    dirty0_write = 1'b0;
    dirty1_write = 1'b0;
    valid0_write = 1'b0;
    valid1_write = 1'b0;
    lru_write    = 1'b0;
    dirty_bit    = 1'b0;
    valid_bit    = 1'b0;
    lru_bit      = 1'b0;
    inmux_sel    = CACHE_IN_PMEM;
    hitmux_sel   = way_to_hitmux(hit_way);
    addrmux_sel  = ADDR_CPU;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;

    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (req && any_hit) begin
            mem_resp  = 1'b1;
            lru_write = 1'b1;
            lru_bit   = ~hit_way;
            // The re-compare after a fill completes a miss, so it is not a hit.
            hit_inc   = ~fill_done_q;
            if (mem_write) begin
              inmux_sel    = CACHE_IN_CPU;
              dirty_bit    = 1'b1;
              data0_write  = ~hit_way;
              data1_write  = hit_way;
              dirty0_write = ~hit_way;
              dirty1_write = hit_way;
            end
          end else if (req) begin
            miss_inc = 1'b1;
            state_d  = victim_dirty ? S_WRITEBACK : S_FILL;
          end
        end
        S_WRITEBACK: begin
          pmem_write  = 1'b1;
          addrmux_sel = ADDR_WB;
          hitmux_sel  = way_to_hitmux(victim);
          if (pmem_resp) state_d = S_FILL;
        end
        S_FILL: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            valid_bit    = 1'b1;
            data0_write  = ~victim;
            data1_write  = victim;
            tag0_write   = ~victim;
            tag1_write   = victim;
            valid0_write = ~victim;
            valid1_write = victim;
            dirty0_write = ~victim;
            dirty1_write = victim;
            fill_done_d  = 1'b1;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_done_q <= fill_done_d;
    end
  end

  sat_counter #(
    .Width(CNT_WIDTH)
  ) u_hit_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .count(hit_count)
  );

  sat_counter #(
    .Width(CNT_WIDTH)
  ) u_miss_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (miss_inc),
    .count(miss_count)
  );

endmodule
